// File: rtl/lbdr_pkg.sv
// Shared definitions for the LBDR routing block.
//   - flit_id encodings and bitwise header/tail decode helpers
//   - 2-bit port codes used by the deroute table
//   - route-hold FSM states
package lbdr_pkg;

  localparam logic [2:0] HDR      = 3'b001;
  localparam logic [2:0] BODY     = 3'b010;
  localparam logic [2:0] TAIL     = 3'b100;
  localparam logic [2:0] HDR_TAIL = 3'b101;

  // Port codes double as bit indices into the one-hot port vector
  // {L,S,W,E,N} and into the connectivity vector {Cs,Cw,Ce,Cn}.
  typedef enum logic [1:0] {
    P_N = 2'd0,
    P_E = 2'd1,
    P_W = 2'd2,
    P_S = 2'd3
  } port_code_e;

  localparam int PORT_L = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  function automatic logic is_hdr(input logic [2:0] id);
    return id[0];
  endfunction

  function automatic logic is_tail(input logic [2:0] id);
    return id[2];
  endfunction

endpackage

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR route computation.
//   cur_addr, dst_addr : {y, x} addresses
//   rxy                : {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cx                 : {Cs,Cw,Ce,Cn}
//   dr                 : deroute table, entry i at [2i+1:2i]
//   ports              : one-hot {L,S,W,E,N} or zero
//   derouted           : selected port came from the deroute table
//   unroutable         : no minimal, local or usable deroute port
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int ADDR_W = X_W + Y_W
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        rxy,
  input  logic [3:0]        cx,
  input  logic [7:0]        dr,
  output logic [4:0]        ports,
  output logic              derouted,
  output logic              unroutable
);

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic n1, s1, e1, w1;
  logic min_n, min_e, min_w, min_s, local_hit;
  logic [1:0] dr_idx;
  port_code_e dr_code;

  assign x_cur = cur_addr[X_W-1:0];
  assign y_cur = cur_addr[ADDR_W-1:X_W];
  assign x_dst = dst_addr[X_W-1:0];
  assign y_dst = dst_addr[ADDR_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  assign min_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
  assign min_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
  assign min_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
  assign min_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];

  assign local_hit = (dst_addr == cur_addr);

  // Deroute entry follows the dominant blocked direction: vertical first.
  assign dr_idx  = n1 ? 2'd0 : s1 ? 2'd3 : e1 ? 2'd1 : 2'd2;
  assign dr_code = port_code_e'(dr[{dr_idx, 1'b0} +: 2]);

  always_comb begin
    ports      = '0;
    derouted   = 1'b0;
    unroutable = 1'b0;
    if (local_hit) begin
      ports[PORT_L] = 1'b1;
    end else if (min_n) begin
      ports[P_N] = 1'b1;
    end else if (min_e) begin
      ports[P_E] = 1'b1;
    end else if (min_w) begin
      ports[P_W] = 1'b1;
    end else if (min_s) begin
      ports[P_S] = 1'b1;
    end else if (cx[dr_code]) begin
      ports[dr_code] = 1'b1;
      derouted       = 1'b1;
    end else begin
      unroutable = 1'b1;
    end
  end

endmodule

// File: rtl/lbdr_dr.sv
// LBDR routing block with deroute table and per-packet route hold.
//   clk, rst        : clock, synchronous active-high reset
//   *_rst           : routing configuration, captured while rst is high
//   empty, flit_id,
//   dst_addr, rd    : input FIFO head and downstream pop
//   N/E/W/S/Lport   : registered one-hot port, held for the packet
//   route_valid     : a route or drop decision is held
//   drop            : current packet is discarded
//   derouted        : current route came from the deroute table
//   err             : sticky protocol/config error
module lbdr_dr
  import lbdr_pkg::*;
#(
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int ADDR_W = X_W + Y_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        Rxy_rst,
  input  logic [3:0]        Cx_rst,
  input  logic [7:0]        Dr_rst,
  input  logic [ADDR_W-1:0] cur_addr_rst,
  input  logic              empty,
  input  logic [2:0]        flit_id,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              rd,
  output logic              Nport,
  output logic              Eport,
  output logic              Wport,
  output logic              Sport,
  output logic              Lport,
  output logic              route_valid,
  output logic              drop,
  output logic              derouted,
  output logic              err
);

  logic [7:0]        rxy_q;
  logic [3:0]        cx_q;
  logic [7:0]        dr_q;
  logic [ADDR_W-1:0] cur_q;

  state_e     state_q, state_d;
  logic [4:0] port_q, port_d;
  logic       rv_q, rv_d, drop_q, drop_d, der_q, der_d, err_q, err_d;

  logic [4:0] calc_ports;
  logic       calc_der, calc_unr;
  logic       hdr, tail;
  logic       unused_flit_bit;

  assign hdr             = is_hdr(flit_id);
  assign tail            = is_tail(flit_id);
  assign unused_flit_bit = flit_id[1];

  // Configuration is loaded only while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q <= Rxy_rst;
      cx_q  <= Cx_rst;
      dr_q  <= Dr_rst;
      cur_q <= cur_addr_rst;
    end
  end

  lbdr_route_calc #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W)
  ) u_calc (
    .cur_addr  (cur_q),
    .dst_addr  (dst_addr),
    .rxy       (rxy_q),
    .cx        (cx_q),
    .dr        (dr_q),
    .ports     (calc_ports),
    .derouted  (calc_der),
    .unroutable(calc_unr)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rv_d    = rv_q;
    drop_d  = drop_q;
    der_d   = der_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // A pop with no held route is a protocol error; a header at the
        // head is still evaluated in the same cycle.
        if (rd) err_d = 1'b1;
        if (!empty) begin
          if (hdr) begin
            rv_d = 1'b1;
            if (calc_unr) begin
              state_d = DROP;
              drop_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = ROUTE;
              port_d  = calc_ports;
              der_d   = calc_der;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ROUTE, DROP: begin
        // Outputs are frozen until the tail is popped.
        if (rd) begin
          if (empty) begin
            err_d = 1'b1;
          end else if (tail) begin
            state_d = IDLE;
            port_d  = '0;
            rv_d    = 1'b0;
            drop_d  = 1'b0;
            der_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        port_d  = '0;
        rv_d    = 1'b0;
        drop_d  = 1'b0;
        der_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      rv_q    <= 1'b0;
      drop_q  <= 1'b0;
      der_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rv_q    <= rv_d;
      drop_q  <= drop_d;
      der_q   <= der_d;
      err_q   <= err_d;
    end
  end

  assign Nport       = port_q[P_N];
  assign Eport       = port_q[P_E];
  assign Wport       = port_q[P_W];
  assign Sport       = port_q[P_S];
  assign Lport       = port_q[PORT_L];
  assign route_valid = rv_q;
  assign drop        = drop_q;
  assign derouted    = der_q;
  assign err         = err_q;

endmodule
